// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that decodes RISC-V OP/OP-IMM ALU instructions, drives a
// registered external ALU, and iterates one-bit shift passes for SLL/SRL.
module alu_sequencer #(
    parameter int SHAMT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic        in_is_imm,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [4:0] SEL_ADD  = 5'b00000;
    localparam logic [4:0] SEL_SUB  = 5'b00001;
    localparam logic [4:0] SEL_SLL  = 5'b00100;
    localparam logic [4:0] SEL_SRL  = 5'b00101;
    localparam logic [4:0] SEL_AND  = 5'b01000;
    localparam logic [4:0] SEL_OR   = 5'b01001;
    localparam logic [4:0] SEL_XOR  = 5'b01010;
    localparam logic [4:0] SEL_SLTU = 5'b01101;
    localparam logic [4:0] SEL_SLT  = 5'b01110;
    localparam logic [4:0] SEL_SRA  = 5'b01111;

    state_t             state_q, state_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic [4:0]         alu_sel_q, alu_sel_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;
    logic               iter_q, iter_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic [SHAMT_W-1:0] dec_shamt;
    logic [4:0]         dec_sel;
    logic [31:0]        dec_b;
    logic               dec_iter;

    // Instruction decode. Iterated shifts move one bit per ALU pass, so the
    // ALU sees a constant shift of 1 and the sequencer counts the passes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements leaves it unassigned (no inferred latch).
        dec_shamt = in_rs2[SHAMT_W-1:0];
        dec_sel   = SEL_ADD;
        dec_b     = in_rs2;
        dec_iter  = 1'b0;
        case (in_funct3)
            3'b000: if (in_funct7b5 && !in_is_imm) dec_sel = SEL_SUB;
            3'b001: begin
                dec_sel  = SEL_SLL;
                dec_b    = 32'd1;
                dec_iter = 1'b1;
            end
            3'b010: dec_sel = SEL_SLT;
            3'b011: dec_sel = SEL_SLTU;
            3'b100: dec_sel = SEL_XOR;
            3'b101: begin
                if (in_funct7b5) begin
                    dec_sel = SEL_SRA;
                    dec_b   = 32'(dec_shamt);
                end else begin
                    dec_sel  = SEL_SRL;
                    dec_b    = 32'd1;
                    dec_iter = 1'b1;
                end
            end
            3'b110: dec_sel = SEL_OR;
            3'b111: dec_sel = SEL_AND;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        remaining_d = remaining_q;
        iter_d      = iter_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_a_d     = in_rs1;
                    alu_b_d     = dec_b;
                    alu_sel_d   = dec_sel;
                    remaining_d = dec_shamt;
                    iter_d      = dec_iter;
                    if (dec_iter && dec_shamt == '0) begin
                        out_data_d  = in_rs1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: state_d = SAMPLE;
            SAMPLE: begin
                if (iter_q && remaining_q > SHAMT_W'(1)) begin
                    alu_a_d     = alu_out;
                    remaining_d = remaining_q - SHAMT_W'(1);
                    state_d     = EXEC;
                end else begin
                    out_data_d  = alu_out;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            remaining_q <= '0;
            iter_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            remaining_q <= remaining_d;
            iter_q      <= iter_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered ALU model on the ALU side and
// an instruction-level reference model predicting result, latency and ALU select.
module tb_alu_sequencer;

    localparam int SHAMT_W = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic        in_is_imm = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [31:0] alu_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(.SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Downstream ALU: result registered one clock after its inputs.
    always @(posedge clk) begin
        case (alu_sel)
            5'b00000: alu_out <= alu_a + alu_b;
            5'b00001: alu_out <= alu_a - alu_b;
            5'b00100: alu_out <= alu_a << alu_b[4:0];
            5'b00101: alu_out <= alu_a >> alu_b[4:0];
            5'b01111: alu_out <= $unsigned($signed(alu_a) >>> alu_b[4:0]);
            5'b01110: alu_out <= ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            5'b01101: alu_out <= (alu_a < alu_b) ? 32'd1 : 32'd0;
            5'b01010: alu_out <= alu_a ^ alu_b;
            5'b01001: alu_out <= alu_a | alu_b;
            5'b01000: alu_out <= alu_a & alu_b;
            default:  alu_out <= 32'hDEAD_BEEF;
        endcase
    end

    // Reference model: architectural result of the instruction.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic f7,
                                               input logic imm, input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        sh = int'(b[SHAMT_W-1:0]);
        case (f3)
            3'd0:    return (f7 && !imm) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7 ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [4:0] ref_sel(input logic [2:0] f3, input logic f7, input logic imm);
        logic [4:0] tbl [8];
        tbl = '{5'b00000, 5'b00100, 5'b01110, 5'b01101, 5'b01010, 5'b00101, 5'b01001, 5'b01000};
        if (f3 == 3'd0 && f7 && !imm) return 5'b00001;
        if (f3 == 3'd5 && f7) return 5'b01111;
        return tbl[f3];
    endfunction

    function automatic bit is_iter(input logic [2:0] f3, input logic f7);
        return (f3 == 3'd1) || (f3 == 3'd5 && !f7);
    endfunction

    function automatic logic [31:0] ref_alu_b(input logic [2:0] f3, input logic f7,
                                              input logic [31:0] b);
        if (is_iter(f3, f7)) return 32'd1;
        if (f3 == 3'd5) return {27'd0, b[4:0]};
        return b;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic f7, input logic [31:0] b);
        int n;
        n = int'(b[SHAMT_W-1:0]);
        if (!is_iter(f3, f7)) return 3;
        if (n == 0) return 1;
        return 1 + 2 * n;
    endfunction

    task automatic scramble_inputs();
        in_funct3   = 3'($urandom);
        in_funct7b5 = 1'($urandom);
        in_is_imm   = 1'($urandom);
        in_rs1      = $urandom;
        in_rs2      = $urandom;
    endtask

    // Issues one instruction, checks decode, latency, result, DONE holding and the handshake.
    task automatic run_op(input logic [2:0] f3, input logic f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b, input int hold,
                          input string name);
        logic [31:0] exp_res, exp_b;
        logic [4:0]  exp_sel;
        int          exp_lat, cyc;
        exp_res = ref_result(f3, f7, imm, a, b);
        exp_sel = ref_sel(f3, f7, imm);
        exp_b   = ref_alu_b(f3, f7, b);
        exp_lat = ref_latency(f3, f7, b);

        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_funct3 = f3; in_funct7b5 = f7; in_is_imm = imm;
        in_rs1 = a; in_rs2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if (alu_a !== a || alu_b !== exp_b || alu_sel !== exp_sel) begin
                    n_errors++;
                    $display("FAIL %s alu inputs: got a=%h b=%h sel=%b want a=%h b=%h sel=%b",
                             name, alu_a, alu_b, alu_sel, a, exp_b, exp_sel);
                end
            end
            if (!out_valid) begin
                n_checks++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s busy/in_ready while working: got %b/%b want 1/0",
                             name, busy, in_ready);
                end
            end
        end while (out_valid !== 1'b1 && cyc < 100);

        n_checks++;
        if (out_valid !== 1'b1 || cyc != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, cyc, out_valid, exp_lat);
        end
        n_checks++;
        if (out_data !== exp_res) begin
            n_errors++;
            $display("FAIL %s out_data: got %h want %h", name, out_data, exp_res);
        end

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            scramble_inputs();
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_res || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s hold %0d: got v=%b d=%h busy=%b rdy=%b want 1 %h 1 0",
                         name, i, out_valid, out_data, busy, in_ready, exp_res);
            end
        end

        // A pending in_valid during the handshake must not be taken in that same cycle.
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after handshake: got v=%b busy=%b rdy=%b want 0 0 1",
                     name, out_valid, busy, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || alu_a !== '0 || alu_b !== '0 ||
            alu_sel !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset values: got v=%b d=%h a=%h b=%h sel=%b busy=%b want all zero",
                     out_valid, out_data, alu_a, alu_b, alu_sel, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        run_op(3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 0, "sub");
        run_op(3'b000, 1'b1, 1'b1, 32'd5, 32'd7, 0, "addi_bit30");
        run_op(3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE4, 0, "sll_4");
        run_op(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd31, 0, "sra_31");
        run_op(3'b101, 1'b0, 1'b1, 32'h0000_1234, 32'hFFFF_FFE0, 0, "srl_0");
        run_op(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
        run_op(3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "sltu_big");
        run_op(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 0, "srl_31");
    endtask

    task automatic test_backpressure();
        run_op(3'b100, 1'b0, 1'b0, $urandom, $urandom, 5, "bp_xor");
        run_op(3'b001, 1'b0, 1'b1, $urandom, 32'd3, 5, "bp_sll");
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; in_funct3 = 3'b001; in_funct7b5 = 1'b0; in_is_imm = 1'b1;
        in_rs1 = $urandom | 32'h1; in_rs2 = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || alu_a === '0) begin
            n_errors++;
            $display("FAIL midshift busy before reset: got busy=%b a=%h want 1 nonzero", busy, alu_a);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || alu_a !== '0 || alu_b !== '0 ||
            alu_sel !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midshift async reset: got v=%b d=%h a=%h b=%h sel=%b busy=%b rdy=%b",
                     out_valid, out_data, alu_a, alu_b, alu_sel, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midshift in_ready after release: got %b want 1", in_ready);
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midshift aborted op resurfaced: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] b;
        for (int i = 0; i < 150; i++) begin
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 2));
            run_op(3'($urandom), 1'($urandom), 1'($urandom), $urandom, b,
                   $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
